hazard_controller: RTL

Sequential pipeline controller for the 5-stage MIPS datapath: it owns all pipeline-latch enables and flushes, and the PC write enable. It resolves memory-wait freezes, load-use stalls, control-flow flushes and halt draining, and keeps saturating stall/flush performance counters. It sits beside the forwarding unit, and covers exactly the hazards forwarding cannot: a load result still in EX, and outstanding memory.

---
 rtl/hazard_controller.sv | 124 ++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: latch enables, flushes, PC enable and halt drain
// for the 5-stage MIPS core, plus saturating stall/flush counters.
module hazard_controller (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dREN_me,
  input  logic        dWEN_me,
  input  logic        halt_me,
  input  logic        load_ex,
  input  logic [4:0]  regDst_ex,
  input  logic [4:0]  rs_de,
  input  logic [4:0]  rt_de,
  input  logic        usesRt_de,
  input  logic        jump_de,
  input  logic        branchTaken_ex,
  output logic        pcEn,
  output logic        en_fd,
  output logic        en_de,
  output logic        en_em,
  output logic        en_mw,
  output logic        flush_fd,
  output logic        flush_de,
  output logic        flush_em,
  output logic        halt,
  output logic [1:0]  state,
  output logic [15:0] stallCnt,
  output logic [15:0] flushCnt
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] MEMWAIT = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] HALT    = 2'd3;

  logic [1:0] state_d;
  logic       mem_busy;
  logic       load_use;
  logic       flush_evt;
  logic       stall_evt;

  assign mem_busy = (dREN_me | dWEN_me) & ~dhit;

  assign load_use = load_ex & (regDst_ex != 5'd0) &
                    ((rs_de == regDst_ex) |
                     (usesRt_de & (rt_de == regDst_ex)));

  always_comb begin
    pcEn      = 1'b0;
    en_fd     = 1'b0;
    en_de     = 1'b0;
    en_em     = 1'b0;
    en_mw     = 1'b0;
    flush_fd  = 1'b0;
    flush_de  = 1'b0;
    flush_em  = 1'b0;
    flush_evt = 1'b0;
    state_d   = state;
    if (!RST) begin
      unique case (state)
        RUN, MEMWAIT: begin
          if (mem_busy) begin
            state_d = MEMWAIT;
          end else if (halt_me) begin
            en_em    = 1'b1;
            en_mw    = 1'b1;
            flush_em = 1'b1;
            state_d  = DRAIN;
          end else begin
            state_d = RUN;
            en_fd   = 1'b1;
            en_de   = 1'b1;
            en_em   = 1'b1;
            en_mw   = 1'b1;
            if (branchTaken_ex) begin
              pcEn      = 1'b1;
              flush_fd  = 1'b1;
              flush_de  = 1'b1;
              flush_evt = 1'b1;
            end else if (load_use) begin
              en_fd    = 1'b0;
              flush_de = 1'b1;
            end else if (jump_de) begin
              pcEn      = 1'b1;
              flush_fd  = 1'b1;
              flush_evt = 1'b1;
            end else if (!ihit) begin
              flush_fd = 1'b1;
            end else begin
              pcEn = 1'b1;
            end
          end
        end
        DRAIN: begin
          en_mw   = 1'b1;
          state_d = HALT;
        end
        HALT: begin
          state_d = HALT;
        end
      endcase
    end
  end

  assign stall_evt = ~pcEn & ((state == RUN) | (state == MEMWAIT));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= RUN;
      halt     <= 1'b0;
      stallCnt <= 16'd0;
      flushCnt <= 16'd0;
    end else begin
      state <= state_d;
      halt  <= halt | (state_d == HALT);
      if (stall_evt && stallCnt != 16'hFFFF)
        stallCnt <= stallCnt + 16'd1;
      if (flush_evt && flushCnt != 16'hFFFF)
        flushCnt <= flushCnt + 16'd1;
    end
  end

endmodule
